// File: rtl/ball_hit_sampler.sv
// Samples the VGA pixel stream at four probes around the ball and publishes one
// {L,T,R,B} hit vector per frame over a valid/ack handshake.
module ball_hit_sampler #(
  parameter int                  BALL_SIZE  = 16,
  parameter int                  COORD_W    = 11,
  parameter int                  COLOR_W    = 8,
  parameter logic [COLOR_W-1:0]  BG_COLOR   = 8'h00,
  parameter logic [COLOR_W-1:0]  BALL_COLOR = 8'hFF,
  parameter int                  SCREEN_W   = 640,
  parameter int                  SCREEN_H   = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               pixel_valid,
  input  logic [COLOR_W-1:0] pixel_color,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  output logic [3:0]         hit_vec,
  output logic               hit_valid,
  input  logic               hit_ack,
  output logic               overrun
);

  typedef logic signed [COORD_W:0] coord_t;
  typedef enum logic {ARM, SCAN} state_t;

  localparam coord_t SIZE  = coord_t'(BALL_SIZE);
  localparam coord_t HALF  = coord_t'(BALL_SIZE / 2);
  localparam coord_t ONE   = coord_t'(1);
  localparam coord_t SCR_W = coord_t'(SCREEN_W);
  localparam coord_t SCR_H = coord_t'(SCREEN_H);

  state_t      state, state_next;
  logic        latch, publish;
  logic [3:0]  acc;
  coord_t      probe_x [4];
  coord_t      probe_y [4];
  coord_t      new_x [4];
  coord_t      new_y [4];
  coord_t      bx, by, pix_x, pix_y;
  logic        color_hit;
  logic [3:0]  off_new, hit_new, hit_cur;

  function automatic logic off_screen(input coord_t x, input coord_t y);
    return (x < 0) || (y < 0) || (x >= SCR_W) || (y >= SCR_H);
  endfunction

  // Candidate probes from the live ball position; index 3..0 = L,T,R,B.
  always_comb begin
    bx       = $signed({1'b0, ball_x});
    by       = $signed({1'b0, ball_y});
    pix_x    = $signed({1'b0, pixel_x});
    pix_y    = $signed({1'b0, pixel_y});
    new_x[3] = bx - ONE;   new_y[3] = by + HALF;
    new_x[2] = bx + HALF;  new_y[2] = by - ONE;
    new_x[1] = bx + SIZE;  new_y[1] = by + HALF;
    new_x[0] = bx + HALF;  new_y[0] = by + SIZE;
    color_hit = pixel_valid && (pixel_color != BG_COLOR) && (pixel_color != BALL_COLOR);
    off_new = '0;
    hit_new = '0;
    hit_cur = '0;
    for (int i = 0; i < 4; i++) begin
      off_new[i] = off_screen(new_x[i], new_y[i]);
      hit_new[i] = color_hit && (pix_x == new_x[i]) && (pix_y == new_y[i]);
      hit_cur[i] = color_hit && (pix_x == probe_x[i]) && (pix_y == probe_y[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ARM && frame_start) state_next = SCAN;
  end

  always_comb begin
    latch   = frame_start;
    publish = frame_start && (state == SCAN);
  end

  // A pixel on the frame_start cycle belongs to the new frame, so it is
  // judged against the freshly computed probes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      for (int i = 0; i < 4; i++) begin
        probe_x[i] <= '0;
        probe_y[i] <= '0;
      end
    end else if (latch) begin
      acc <= off_new | hit_new;
      for (int i = 0; i < 4; i++) begin
        probe_x[i] <= new_x[i];
        probe_y[i] <= new_y[i];
      end
    end else if (state == SCAN) begin
      acc <= acc | hit_cur;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_vec   <= '0;
      hit_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (publish) begin
        if (!hit_valid || hit_ack) begin
          hit_vec   <= acc;
          hit_valid <= 1'b1;
        end else begin
          hit_vec <= hit_vec | acc;
          overrun <= 1'b1;
        end
      end else if (hit_valid && hit_ack) begin
        hit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ball_hit_sampler.sv
// Directed bench for ball_hit_sampler: probe hits, off-screen probes,
// merge/overrun, handshake and asynchronous reset.
module tb_ball_hit_sampler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [10:0] pixel_x = '0;
  logic [10:0] pixel_y = '0;
  logic        pixel_valid = 1'b0;
  logic [7:0]  pixel_color = '0;
  logic [10:0] ball_x = '0;
  logic [10:0] ball_y = '0;
  logic [3:0]  hit_vec;
  logic        hit_valid;
  logic        hit_ack = 1'b0;
  logic        overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  ball_hit_sampler dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_color(pixel_color), .ball_x(ball_x), .ball_y(ball_y),
    .hit_vec(hit_vec), .hit_valid(hit_valid), .hit_ack(hit_ack),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic [7:0] c, input logic v);
    pixel_x = 11'(x); pixel_y = 11'(y); pixel_color = c; pixel_valid = v;
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic fs(input logic ack);
    frame_start = 1'b1; hit_ack = ack;
    tick();
    frame_start = 1'b0; hit_ack = 1'b0;
  endtask

  task automatic ack_once();
    hit_ack = 1'b1;
    tick();
    hit_ack = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [3:0] v, input logic val,
                            input logic ovr);
    total_cnt++;
    if (hit_vec !== v || hit_valid !== val || overrun !== ovr)
      $display("FAIL %s: got vec=%b valid=%b ovr=%b, want vec=%b valid=%b ovr=%b",
               name, hit_vec, hit_valid, overrun, v, val, ovr);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    expect_out("reset_state", 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_right_hit();
    ball_x = 11'd100; ball_y = 11'd100;
    fs(1'b0);
    expect_out("arm_no_publish", 4'b0000, 1'b0, 1'b0);
    pix(116, 108, 8'hE0, 1'b1);
    pix(50, 50, 8'hE0, 1'b1);
    fs(1'b0);
    expect_out("right_hit", 4'b0010, 1'b1, 1'b0);
    ack_once();
    expect_out("ack_clears", 4'b0010, 1'b0, 1'b0);
    ack_once();
    expect_out("ack_idle_ignored", 4'b0010, 1'b0, 1'b0);
  endtask

  task automatic test_off_screen();
    ball_x = 11'd0; ball_y = 11'd50;
    fs(1'b0);
    expect_out("empty_frame", 4'b0000, 1'b1, 1'b0);
    ack_once();
    pix(8, 49, 8'h00, 1'b1);
    ball_x = 11'd624; ball_y = 11'd464;
    fs(1'b0);
    expect_out("left_offscreen", 4'b1000, 1'b1, 1'b0);
    ack_once();
    ball_x = 11'd100; ball_y = 11'd100;
    fs(1'b0);
    expect_out("right_bottom_offscreen", 4'b0011, 1'b1, 1'b0);
    ack_once();
  endtask

  task automatic test_back_to_back();
    pix(108, 99, 8'hE0, 1'b1);
    fs(1'b0);
    expect_out("frame_n_top", 4'b0100, 1'b1, 1'b0);
    pix(108, 116, 8'h1C, 1'b1);
    fs(1'b0);
    expect_out("merged_overrun", 4'b0101, 1'b1, 1'b1);
    tick();
    expect_out("overrun_one_cycle", 4'b0101, 1'b1, 1'b0);
    ack_once();
  endtask

  task automatic test_ack_with_frame();
    pix(99, 108, 8'h1C, 1'b1);
    fs(1'b0);
    expect_out("pending_left", 4'b1000, 1'b1, 1'b0);
    pix(116, 108, 8'hE0, 1'b1);
    fs(1'b1);
    expect_out("ack_same_cycle_replace", 4'b0010, 1'b1, 1'b0);
    ack_once();
  endtask

  task automatic test_filters();
    pix(116, 108, 8'hFF, 1'b1);
    pix(99, 108, 8'hE0, 1'b0);
    ball_y = 11'd200;
    pix(108, 116, 8'hE0, 1'b1);
    pix(116, 208, 8'hE0, 1'b1);
    fs(1'b0);
    expect_out("filters_old_probes", 4'b0001, 1'b1, 1'b0);
    ack_once();
    pix(99, 108, 8'hE0, 1'b1);
    pix(116, 208, 8'hE0, 1'b1);
    fs(1'b0);
    expect_out("new_probes_after_latch", 4'b0010, 1'b1, 1'b0);
    ack_once();
    ball_y = 11'd100;
    fs(1'b0);
    ack_once();
  endtask

  task automatic test_async_reset();
    pix(108, 99, 8'hE0, 1'b1);
    fs(1'b0);
    expect_out("pre_reset_pending", 4'b0100, 1'b1, 1'b0);
    pix(99, 108, 8'hE0, 1'b1);
    #2 reset = 1'b1;
    #1;
    expect_out("async_reset_immediate", 4'b0000, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    pix(99, 108, 8'hE0, 1'b1);
    fs(1'b0);
    expect_out("rearm_no_publish", 4'b0000, 1'b0, 1'b0);
    pix(116, 108, 8'hE0, 1'b1);
    fs(1'b0);
    expect_out("after_rearm_publish", 4'b0010, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_right_hit();
    test_off_screen();
    test_back_to_back();
    test_ack_with_frame();
    test_filters();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
